keypad_scan_fifo: RTL and testbench

KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

---
 rtl/keypad_scan_fifo.sv | 227 ++++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
// Row-scanned matrix keypad with debounce, optional typematic repeat and an
// event FIFO that carries {repeat, code} records to the consumer.
module keypad_scan_fifo #(
   parameter int NROWS           = 4,
   parameter int NCOLS           = 4,
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int FIFO_DEPTH      = 4,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_RATE     = 16,
   localparam int CODE_W         = $clog2(NROWS*NCOLS),
   localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [NROWS-1:0]  row_n,
   input  logic [NCOLS-1:0]  col_n,
   input  logic              clear_ovf,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CODE_W-1:0] evt_code,
   output logic              evt_repeat,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              overflow,
   output logic              key_held
);

   localparam int ROW_W   = (NROWS > 1) ? $clog2(NROWS) : 1;
   localparam int COL_W   = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int DIV_W   = $clog2(SCAN_DIV);
   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX) + 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENT_W   = CODE_W + 1;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d, row_next;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DEB_W-1:0]   deb_q, deb_d;
   logic [RPT_W-1:0]   rpt_q, rpt_d, rpt_lim;
   logic               first_q, first_d;
   logic [COL_W-1:0]   col_q, col_d, col_idx;
   logic [NCOLS-1:0]   pat_q, pat_d;
   logic               held_q, held_d;
   logic [NCOLS-1:0]   sync1_q, cols_q;
   logic               push, push_rpt;
   logic [CODE_W-1:0]  code;

   logic [ENT_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               full, pop, wr_en, drop;
   logic [ENT_W-1:0]   head;

   // Two-flop synchronizer; idle (all-ones) out of reset so nothing looks pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         cols_q  <= '1;
      end else begin
         sync1_q <= col_n;
         cols_q  <= sync1_q;
      end
   end

   always_comb begin
      col_idx = '0;
      for (int c = 0; c < NCOLS; c++) begin
         if (!cols_q[c]) col_idx = COL_W'(c);
      end
   end

   assign row_next = (row_q == ROW_W'(NROWS-1)) ? '0 : row_q + ROW_W'(1);
   assign rpt_lim  = first_q ? RPT_W'(REPEAT_DELAY-1) : RPT_W'(REPEAT_RATE-1);
   assign code     = CODE_W'(int'(row_q) * NCOLS + int'(col_q));
   assign row_n    = ~(NROWS'(1) << row_q);
   assign key_held = held_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCAN;
         row_q   <= '0;
         div_q   <= '0;
         deb_q   <= '0;
         rpt_q   <= '0;
         first_q <= 1'b1;
         col_q   <= '0;
         pat_q   <= '1;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         div_q   <= div_d;
         deb_q   <= deb_d;
         rpt_q   <= rpt_d;
         first_q <= first_d;
         col_q   <= col_d;
         pat_q   <= pat_d;
         held_q  <= held_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      div_d    = div_q;
      deb_d    = deb_q;
      rpt_d    = rpt_q;
      first_d  = first_q;
      col_d    = col_q;
      pat_d    = pat_q;
      held_d   = held_q;
      push     = 1'b0;
      push_rpt = 1'b0;
      case (state_q)
         SCAN: begin
            // colS lags the row drive by two flops, so only the last divider cycle is trusted.
            if (div_q == DIV_W'(SCAN_DIV-1)) begin
               div_d = '0;
               if ($onehot(~cols_q)) begin
                  col_d   = col_idx;
                  pat_d   = cols_q;
                  deb_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  row_d = row_next;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DEBOUNCE: begin
            if (cols_q != pat_q) begin
               state_d = SCAN;
               row_d   = row_next;
               div_d   = '0;
            end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES-1)) begin
               push    = 1'b1;
               held_d  = 1'b1;
               rpt_d   = '0;
               first_d = 1'b1;
               state_d = HELD;
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         HELD: begin
            if (&cols_q) begin
               state_d = RELEASE;
               deb_d   = '0;
            end else if (REPEAT_EN != 0) begin
               if (rpt_q == rpt_lim) begin
                  push     = 1'b1;
                  push_rpt = 1'b1;
                  rpt_d    = '0;
                  first_d  = 1'b0;
               end else begin
                  rpt_d = rpt_q + RPT_W'(1);
               end
            end
         end
         RELEASE: begin
            // Repeat timer is deliberately left untouched so a re-press resumes it.
            if (!cols_q[col_q]) begin
               state_d = HELD;
            end else if (!(&cols_q)) begin
               deb_d = '0;
            end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES-1)) begin
               held_d  = 1'b0;
               state_d = SCAN;
               row_d   = row_next;
               div_d   = '0;
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         default: state_d = SCAN;
      endcase
   end

   assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign pop   = (cnt_q != '0) && evt_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_comb begin
      cnt_d = cnt_q;
      case ({wr_en, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      ovf_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // When full with a pop, the write lands in the slot being vacated by the head.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= {push_rpt, code};
   end

   assign head       = mem[rd_ptr_q];
   assign evt_valid  = (cnt_q != '0);
   assign evt_code   = evt_valid ? head[CODE_W-1:0] : '0;
   assign evt_repeat = evt_valid ? head[CODE_W] : 1'b0;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench: a default instance plus a repeat-enabled instance, each driven
// by a simple 4x4 key-matrix model.
module tb_keypad_scan_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  row_n, row_n_r;
   logic [3:0]  col_n, col_n_r;
   logic        clear_ovf = 1'b0, clear_ovf_r = 1'b0;
   logic        evt_valid, evt_valid_r;
   logic        evt_ready = 1'b1, evt_ready_r = 1'b1;
   logic [3:0]  evt_code, evt_code_r;
   logic        evt_repeat, evt_repeat_r;
   logic [2:0]  fifo_count, fifo_count_r;
   logic        overflow, overflow_r;
   logic        key_held, key_held_r;
   logic [15:0] keys = '0, keys_r = '0;

   int cyc = 0;
   int n_assert = 0;
   int n_fail = 0;

   typedef struct {int cyc; int code; int rpt;} ev_t;
   ev_t q[$];
   ev_t qr[$];

   keypad_scan_fifo dut (
      .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .clear_ovf(clear_ovf),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_repeat(evt_repeat), .fifo_count(fifo_count), .overflow(overflow),
      .key_held(key_held)
   );

   keypad_scan_fifo #(.REPEAT_EN(1)) dut_r (
      .clk(clk), .rst_n(rst_n), .row_n(row_n_r), .col_n(col_n_r), .clear_ovf(clear_ovf_r),
      .evt_valid(evt_valid_r), .evt_ready(evt_ready_r), .evt_code(evt_code_r),
      .evt_repeat(evt_repeat_r), .fifo_count(fifo_count_r), .overflow(overflow_r),
      .key_held(key_held_r)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Key matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col_n   = '1;
      col_n_r = '1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_n[r] && keys[r*4+c])     col_n[c]   = 1'b0;
            if (!row_n_r[r] && keys_r[r*4+c]) col_n_r[c] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      ev_t e;
      if (evt_valid && evt_ready) begin
         e.cyc = cyc; e.code = int'(evt_code); e.rpt = int'(evt_repeat);
         q.push_back(e);
      end
      if (evt_valid_r && evt_ready_r) begin
         e.cyc = cyc; e.code = int'(evt_code_r); e.rpt = int'(evt_repeat_r);
         qr.push_back(e);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_held(input logic val, input int max, input string tag);
      int n = 0;
      while (key_held !== val && n < max) begin
         step(1);
         n++;
      end
      check(tag, 32'(key_held), 32'(val));
   endtask

   task automatic wait_row(input logic [3:0] pat, input string tag);
      int n = 0;
      while (row_n !== pat && n < 100) begin
         step(1);
         n++;
      end
      check(tag, 32'(row_n), 32'(pat));
   endtask

   task automatic press_release(input int code, input string tag);
      keys = 16'(1) << code;
      wait_held(1'b1, 200, {tag, "_held"});
      keys = '0;
      wait_held(1'b0, 60, {tag, "_rel"});
   endtask

   function automatic int qr_field(input int i, input int which);
      if (i >= qr.size()) return -1;
      case (which)
         0: return qr[i].code;
         1: return qr[i].rpt;
         default: return qr[i].cyc;
      endcase
   endfunction

   initial begin
      int n;
      int exp_rpt[5];
      int exp_gap[5];
      exp_rpt = '{0, 1, 1, 1, 1};
      exp_gap = '{0, 32, 16, 16, 16};

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      check("rst_row_n", 32'(row_n), 32'hE);
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_code", 32'(evt_code), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_held", 32'(key_held), 0);
      step(3);
      rst_n = 1'b1;
      step(5);

      // Single key (row 2, col 1) held 200 cycles
      q.delete();
      keys = 16'(1) << 9;
      step(200);
      check("k9_held", 32'(key_held), 1);
      check("k9_nevt", 32'(q.size()), 1);
      if (q.size() > 0) begin
         check("k9_code", 32'(q[0].code), 9);
         check("k9_rpt", 32'(q[0].rpt), 0);
      end
      keys = '0;
      n = 0;
      while (key_held && n < 40) begin
         step(1);
         n++;
      end
      check("k9_rel_fell", 32'(key_held), 0);
      check("k9_rel_lat_le11", 32'(n <= 11), 1);
      step(20);
      check("k9_no_rel_evt", 32'(q.size()), 1);

      // Bouncing key 6, then stable
      q.delete();
      for (int i = 0; i < 20; i++) begin
         keys = (i % 2 == 0) ? 16'(1) << 6 : '0;
         step(3);
      end
      check("bounce_nevt", 32'(q.size()), 0);
      check("bounce_held", 32'(key_held), 0);
      keys = 16'(1) << 6;
      wait_held(1'b1, 200, "bounce_stable_held");
      step(2);
      check("bounce_stable_nevt", 32'(q.size()), 1);
      if (q.size() > 0) check("bounce_code", 32'(q[0].code), 6);
      keys = '0;
      wait_held(1'b0, 60, "bounce_rel");

      // Two keys in row 0 (cols 0 and 3)
      q.delete();
      keys = 16'h0009;
      step(100);
      check("dual_nevt", 32'(q.size()), 0);
      check("dual_held", 32'(key_held), 0);
      keys = '0;
      step(10);

      // Second key while first is held
      q.delete();
      keys = 16'(1) << 9;
      wait_held(1'b1, 200, "two_first_held");
      keys = keys | (16'(1) << 5);
      step(60);
      check("two_nevt_while_held", 32'(q.size()), 1);
      keys = 16'(1) << 5;
      n = 0;
      while (q.size() < 2 && n < 200) begin
         step(1);
         n++;
      end
      check("two_nevt_after", 32'(q.size()), 2);
      if (q.size() > 1) check("two_second_code", 32'(q[1].code), 5);
      keys = '0;
      wait_held(1'b0, 60, "two_rel");
      step(5);

      // Typematic repeat on the repeat-enabled instance
      qr.delete();
      keys_r = 16'(1) << 5;
      n = 0;
      while (!key_held_r && n < 200) begin
         step(1);
         n++;
      end
      check("rpt_held", 32'(key_held_r), 1);
      step(90);
      keys_r = '0;
      step(40);
      check("rpt_nevt", 32'(qr.size()), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rpt_code%0d", i), 32'(qr_field(i, 0)), 5);
         check($sformatf("rpt_flag%0d", i), 32'(qr_field(i, 1)), 32'(exp_rpt[i]));
         if (i > 0)
            check($sformatf("rpt_gap%0d", i), 32'(qr_field(i, 2) - qr_field(i-1, 2)), 32'(exp_gap[i]));
      end

      // FIFO fill and overflow with consumer stalled
      q.delete();
      evt_ready = 1'b0;
      press_release(0, "ovf_p0");
      press_release(3, "ovf_p1");
      press_release(6, "ovf_p2");
      press_release(10, "ovf_p3");
      check("ovf_not_yet", 32'(overflow), 0);
      press_release(12, "ovf_p4");
      press_release(15, "ovf_p5");
      check("ovf_count", 32'(fifo_count), 4);
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_head_valid", 32'(evt_valid), 1);
      check("ovf_head_code", 32'(evt_code), 0);
      step(3);
      check("ovf_head_stable", 32'(evt_code), 0);
      clear_ovf = 1'b1;
      step(1);
      clear_ovf = 1'b0;
      check("ovf_cleared", 32'(overflow), 0);
      evt_ready = 1'b1;
      step(10);
      check("drain_nevt", 32'(q.size()), 4);
      check("drain_count", 32'(fifo_count), 0);
      if (q.size() == 4) begin
         check("drain_c0", 32'(q[0].code), 0);
         check("drain_c1", 32'(q[1].code), 3);
         check("drain_c2", 32'(q[2].code), 6);
         check("drain_c3", 32'(q[3].code), 10);
      end

      // Reset mid-debounce
      q.delete();
      keys = '0;
      wait_row(4'b1110, "mid_row0");
      keys = 16'(1) << 9;
      wait_row(4'b1011, "mid_row2");
      step(6);
      check("mid_still_row2", 32'(row_n), 32'hB);
      rst_n = 1'b0;
      #1;
      check("mid_rst_row_n", 32'(row_n), 32'hE);
      check("mid_rst_count", 32'(fifo_count), 0);
      check("mid_rst_held", 32'(key_held), 0);
      keys = '0;
      step(2);
      rst_n = 1'b1;
      check("mid_restart_row0", 32'(row_n), 32'hE);
      step(40);
      check("mid_nevt", 32'(q.size()), 0);
      check("mid_held_after", 32'(key_held), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
